// File: rtl/gfx_cmd_decode_engine.sv
// Byte-stream command decoder: parses FILL_RECT / FILL_PIXEL commands into a held valid/ready command.
// Optional screen clipping of origin/size is enabled by defining CMD_DECODE_CLIP_EN (adds port clip_drop).
module gfx_cmd_decode_engine #(
  parameter int COORD_BYTES = 2,
  parameter int COLOR_W     = 4,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  localparam int COORD_W    = 8 * COORD_BYTES
) (
  input  logic               clk,
  input  logic               rst_,
  output logic               cmd_fifo_rtr,
  input  logic               cmd_fifo_rts,
  input  logic [7:0]         cmd_fifo_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_opcode,
  output logic [COORD_W-1:0] cmd_origx,
  output logic [COORD_W-1:0] cmd_origy,
  output logic [COORD_W-1:0] cmd_wid,
  output logic [COORD_W-1:0] cmd_hgt,
  output logic [COLOR_W-1:0] cmd_rval,
  output logic [COLOR_W-1:0] cmd_gval,
  output logic [COLOR_W-1:0] cmd_bval,
  output logic               addr_start_strobe,
  output logic               bad_opcode
`ifdef CMD_DECODE_CLIP_EN
  ,
  output logic               clip_drop
`endif
);

  typedef enum logic [1:0] {S_OPC, S_FIELD, S_HOLD} state_t;
  typedef enum logic [2:0] {F_ORIGX, F_ORIGY, F_WID, F_HGT, F_R, F_G, F_B} field_t;

  localparam logic [1:0] LAST_BYTE = 2'(COORD_BYTES - 1);

  state_t     state, state_nxt;
  field_t     field, field_nxt;
  logic [1:0] byte_cnt, byte_nxt;
  logic       xfc;
  logic       is_coord;
  logic       addr_nxt;
  logic       bad_nxt;
  logic       drop_nxt;
  logic       origin_oob;
  logic       drop_q;

  function automatic logic [COORD_W-1:0] shift_in(input logic [COORD_W-1:0] cur,
                                                  input logic [7:0] b);
    return COORD_W'({cur, b});
  endfunction

  assign cmd_fifo_rtr = (state != S_HOLD);
  assign cmd_valid    = (state == S_HOLD);
  assign xfc          = cmd_fifo_rtr & cmd_fifo_rts;
  assign is_coord     = (field == F_ORIGX) || (field == F_ORIGY) ||
                        (field == F_WID)   || (field == F_HGT);

`ifdef CMD_DECODE_CLIP_EN
  localparam logic [COORD_W:0] SW_EXT = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SH_EXT = (COORD_W+1)'(SCREEN_H);

  logic [COORD_W:0]   room_x, room_y;
  logic [COORD_W-1:0] wid_clip, hgt_clip;

  // Origin bounds use the incoming last origy byte so the drop decision lands with the strobe.
  always_comb begin
    origin_oob = ({1'b0, cmd_origx} >= SW_EXT) ||
                 ({1'b0, shift_in(cmd_origy, cmd_fifo_data)} >= SH_EXT);
    room_x     = SW_EXT - {1'b0, cmd_origx};
    room_y     = SH_EXT - {1'b0, cmd_origy};
    wid_clip   = ({1'b0, cmd_wid} > room_x) ? COORD_W'(room_x) : cmd_wid;
    hgt_clip   = ({1'b0, cmd_hgt} > room_y) ? COORD_W'(room_y) : cmd_hgt;
  end
`else
  assign origin_oob = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= S_OPC;
      field    <= F_ORIGX;
      byte_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      field    <= field_nxt;
      byte_cnt <= byte_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    field_nxt = field;
    byte_nxt  = byte_cnt;
    addr_nxt  = 1'b0;
    bad_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      S_OPC: begin
        if (xfc) begin
          if (cmd_fifo_data == 8'h01 || cmd_fifo_data == 8'h02) begin
            state_nxt = S_FIELD;
            field_nxt = F_ORIGX;
            byte_nxt  = 2'd0;
          end else begin
            bad_nxt = 1'b1;
          end
        end
      end
      S_FIELD: begin
        if (xfc) begin
          if (is_coord && byte_cnt != LAST_BYTE) begin
            byte_nxt = byte_cnt + 2'd1;
          end else begin
            byte_nxt = 2'd0;
            case (field)
              F_ORIGX: field_nxt = F_ORIGY;
              F_ORIGY: begin
                addr_nxt  = ~origin_oob;
                field_nxt = cmd_opcode ? F_R : F_WID;
              end
              F_WID:   field_nxt = F_HGT;
              F_HGT:   field_nxt = F_R;
              F_R:     field_nxt = F_G;
              F_G:     field_nxt = F_B;
              F_B: begin
                field_nxt = F_ORIGX;
                state_nxt = drop_q ? S_OPC : S_HOLD;
                drop_nxt  = drop_q;
              end
              default: field_nxt = F_ORIGX;
            endcase
          end
        end
      end
      S_HOLD: begin
        if (cmd_ready) state_nxt = S_OPC;
      end
      default: state_nxt = S_OPC;
    endcase
  end

  // Field registers update only on their own byte transfer; frozen while holding.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cmd_opcode        <= 1'b0;
      cmd_origx         <= '0;
      cmd_origy         <= '0;
      cmd_wid           <= '0;
      cmd_hgt           <= '0;
      cmd_rval          <= '0;
      cmd_gval          <= '0;
      cmd_bval          <= '0;
      addr_start_strobe <= 1'b0;
      bad_opcode        <= 1'b0;
      drop_q            <= 1'b0;
    end else begin
      addr_start_strobe <= addr_nxt;
      bad_opcode        <= bad_nxt;
      if (xfc && state == S_OPC && !bad_nxt) begin
        cmd_opcode <= (cmd_fifo_data == 8'h02);
        drop_q     <= 1'b0;
        if (cmd_fifo_data == 8'h02) begin
          cmd_wid <= COORD_W'(1);
          cmd_hgt <= COORD_W'(1);
        end
      end
      if (xfc && state == S_FIELD) begin
        case (field)
          F_ORIGX: cmd_origx <= shift_in(cmd_origx, cmd_fifo_data);
          F_ORIGY: begin
            cmd_origy <= shift_in(cmd_origy, cmd_fifo_data);
            if (byte_cnt == LAST_BYTE) drop_q <= origin_oob;
          end
          F_WID:   cmd_wid <= shift_in(cmd_wid, cmd_fifo_data);
          F_HGT:   cmd_hgt <= shift_in(cmd_hgt, cmd_fifo_data);
          F_R: begin
            cmd_rval <= cmd_fifo_data[COLOR_W-1:0];
`ifdef CMD_DECODE_CLIP_EN
            cmd_wid  <= wid_clip;
            cmd_hgt  <= hgt_clip;
`endif
          end
          F_G:     cmd_gval <= cmd_fifo_data[COLOR_W-1:0];
          F_B:     cmd_bval <= cmd_fifo_data[COLOR_W-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef CMD_DECODE_CLIP_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) clip_drop <= 1'b0;
    else       clip_drop <= drop_nxt;
  end
`endif

endmodule

// File: tb/tb_gfx_cmd_decode_engine.sv
// Directed self-checking bench for gfx_cmd_decode_engine (default parameters).
// Clip scenario runs only when CMD_DECODE_CLIP_EN is defined.
module tb_gfx_cmd_decode_engine;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        cmd_fifo_rtr;
  logic        cmd_fifo_rts = 1'b0;
  logic [7:0]  cmd_fifo_data = 8'h00;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_opcode;
  logic [15:0] cmd_origx, cmd_origy, cmd_wid, cmd_hgt;
  logic [3:0]  cmd_rval, cmd_gval, cmd_bval;
  logic        addr_start_strobe;
  logic        bad_opcode;
`ifdef CMD_DECODE_CLIP_EN
  logic        clip_drop;
`endif

  int errors = 0;
  int checks = 0;

  gfx_cmd_decode_engine dut (
    .clk(clk), .rst_(rst_),
    .cmd_fifo_rtr(cmd_fifo_rtr), .cmd_fifo_rts(cmd_fifo_rts), .cmd_fifo_data(cmd_fifo_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_origx(cmd_origx), .cmd_origy(cmd_origy), .cmd_wid(cmd_wid), .cmd_hgt(cmd_hgt),
    .cmd_rval(cmd_rval), .cmd_gval(cmd_gval), .cmd_bval(cmd_bval),
    .addr_start_strobe(addr_start_strobe), .bad_opcode(bad_opcode)
`ifdef CMD_DECODE_CLIP_EN
    , .clip_drop(clip_drop)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [76:0] fields();
    return {cmd_opcode, cmd_origx, cmd_origy, cmd_wid, cmd_hgt, cmd_rval, cmd_gval, cmd_bval};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and returns 1ns after the edge that consumed it.
  task automatic push(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    cmd_fifo_data = b;
    cmd_fifo_rts  = 1'b1;
    while (!cmd_fifo_rtr && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("[TB] FAIL push_timeout: rtr stayed %b, required 1", cmd_fifo_rtr);
    end
    @(posedge clk);
    #1;
    cmd_fifo_rts = 1'b0;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    repeat (2) tick();
    checks++;
    if ({cmd_fifo_rtr, cmd_valid, addr_start_strobe, bad_opcode} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 1000",
               {cmd_fifo_rtr, cmd_valid, addr_start_strobe, bad_opcode});
    end
    checks++;
    if (fields() !== 77'd0) begin
      errors++;
      $display("[TB] FAIL reset_fields: got %h required 0", fields());
    end
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_fill_rect();
    logic [7:0] seq [12] = '{8'h01, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h00, 8'h05,
                             8'h00, 8'h03, 8'h0F, 8'h08, 8'h01};
    for (int i = 0; i < 12; i++) begin
      push(seq[i]);
      if (i >= 3 && i <= 5) begin
        checks++;
        if (addr_start_strobe !== (i == 4)) begin
          errors++;
          $display("[TB] FAIL rect_addr_strobe byte%0d: got %b required %b",
                   i, addr_start_strobe, (i == 4));
        end
      end
    end
    checks++;
    if ({cmd_valid, cmd_fifo_rtr} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rect_valid: got %b required 10", {cmd_valid, cmd_fifo_rtr});
    end
    checks++;
    if (fields() !== {1'b0, 16'd10, 16'd20, 16'd5, 16'd3, 4'hF, 4'h8, 4'h1}) begin
      errors++;
      $display("[TB] FAIL rect_fields: got %h", fields());
    end
    accept();
    checks++;
    if ({cmd_valid, cmd_fifo_rtr} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL rect_release: got %b required 01", {cmd_valid, cmd_fifo_rtr});
    end
  endtask

  task automatic test_fill_pixel();
    logic [7:0] seq [8] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h20, 8'h07, 8'h07, 8'h07};
    for (int i = 0; i < 8; i++) push(seq[i]);
    checks++;
    if (fields() !== {1'b1, 16'd256, 16'd32, 16'd1, 16'd1, 4'h7, 4'h7, 4'h7}) begin
      errors++;
      $display("[TB] FAIL pixel_fields: got %h", fields());
    end
    repeat (3) begin
      tick();
      checks++;
      if ({cmd_valid, cmd_fifo_rtr} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL pixel_hold: got %b required 10", {cmd_valid, cmd_fifo_rtr});
      end
    end
    accept();
    checks++;
    if ({cmd_valid, cmd_fifo_rtr} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL pixel_release: got %b required 01", {cmd_valid, cmd_fifo_rtr});
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] seq [12] = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h07,
                             8'h00, 8'h02, 8'h05, 8'h0A, 8'h0C};
    push(8'h55);
    checks++;
    if ({bad_opcode, cmd_fifo_rtr} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL bad_opc_pulse: got %b required 11", {bad_opcode, cmd_fifo_rtr});
    end
    tick();
    checks++;
    if (bad_opcode !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bad_opc_width: got %b required 0", bad_opcode);
    end
    for (int i = 0; i < 12; i++) push(seq[i]);
    checks++;
    if ({cmd_valid, fields()} !== {1'b1, 1'b0, 16'd3, 16'd4, 16'd7, 16'd2, 4'h5, 4'hA, 4'hC}) begin
      errors++;
      $display("[TB] FAIL bad_opc_next_cmd: got %h", {cmd_valid, fields()});
    end
    accept();
  endtask

  task automatic test_stall_hold();
    logic [7:0] seq [12] = '{8'h01, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33,
                             8'h00, 8'h44, 8'h09, 8'h06, 8'h03};
    logic [76:0] exp = {1'b0, 16'h11, 16'h22, 16'h33, 16'h44, 4'h9, 4'h6, 4'h3};
    for (int i = 0; i < 12; i++) begin
      tick();
      push(seq[i]);
    end
    cmd_fifo_data = 8'hAA;
    cmd_fifo_rts  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({cmd_valid, cmd_fifo_rtr, fields()} !== {2'b10, exp}) begin
        errors++;
        $display("[TB] FAIL stall_hold cyc%0d: got %h required %h",
                 c, {cmd_valid, cmd_fifo_rtr, fields()}, {2'b10, exp});
      end
    end
    cmd_fifo_rts = 1'b0;
    accept();
    checks++;
    if ({cmd_valid, bad_opcode, fields()} !== {2'b00, exp}) begin
      errors++;
      $display("[TB] FAIL stall_release: got %h", {cmd_valid, bad_opcode, fields()});
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] seq [12] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h10,
                             8'h00, 8'h08, 8'h03, 8'h0C, 8'h0F};
    push(8'h01);
    push(8'h00);
    push(8'h0A);
    rst_ = 1'b0;
    #2;
    checks++;
    if ({cmd_valid, cmd_fifo_rtr, cmd_origx} !== {2'b01, 16'd0}) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: got %h required %h",
               {cmd_valid, cmd_fifo_rtr, cmd_origx}, {2'b01, 16'd0});
    end
    @(negedge clk);
    rst_ = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push(seq[i]);
      if (i < 11) begin
        checks++;
        if (cmd_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL mid_reset_early_valid byte%0d: got %b required 0", i, cmd_valid);
        end
      end
    end
    checks++;
    if ({cmd_valid, fields()} !== {1'b1, 1'b0, 16'd256, 16'd200, 16'd16, 16'd8, 4'h3, 4'hC, 4'hF}) begin
      errors++;
      $display("[TB] FAIL mid_reset_new_cmd: got %h", {cmd_valid, fields()});
    end
    accept();
  endtask

`ifdef CMD_DECODE_CLIP_EN
  task automatic test_clip();
    logic [7:0] seq_a [12] = '{8'h01, 8'h02, 8'h76, 8'h00, 8'h0A, 8'h00, 8'h14,
                               8'h00, 8'h05, 8'h01, 8'h02, 8'h03};
    logic [7:0] seq_b [12] = '{8'h01, 8'h02, 8'hBC, 8'h00, 8'h0A, 8'h00, 8'h05,
                               8'h00, 8'h05, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 12; i++) push(seq_a[i]);
    checks++;
    if ({cmd_valid, fields()} !== {1'b1, 1'b0, 16'd630, 16'd10, 16'd10, 16'd5, 4'h1, 4'h2, 4'h3}) begin
      errors++;
      $display("[TB] FAIL clip_width: got %h", {cmd_valid, fields()});
    end
    accept();
    for (int i = 0; i < 12; i++) begin
      push(seq_b[i]);
      checks++;
      if ({addr_start_strobe, cmd_valid, clip_drop} !== {2'b00, (i == 11)}) begin
        errors++;
        $display("[TB] FAIL clip_drop byte%0d: got %b required %b",
                 i, {addr_start_strobe, cmd_valid, clip_drop}, {2'b00, (i == 11)});
      end
    end
    tick();
    checks++;
    if ({cmd_valid, clip_drop, cmd_fifo_rtr} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL clip_after: got %b required 001", {cmd_valid, clip_drop, cmd_fifo_rtr});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_rect();
    test_fill_pixel();
    test_bad_opcode();
    test_stall_hold();
    test_mid_reset();
`ifdef CMD_DECODE_CLIP_EN
    test_clip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
